// File: rtl/pixel_frame_ctrl_pkg.sv
// Shared definitions for the pixel frame controller: state encoding,
// default 800x600 timing and counter sizing helper.
package pixel_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H_ACTIVE   = 800;
  localparam int DEF_H_FP       = 40;
  localparam int DEF_H_SYNC     = 128;
  localparam int DEF_H_BP       = 88;
  localparam int DEF_V_ACTIVE   = 600;
  localparam int DEF_V_FP       = 1;
  localparam int DEF_V_SYNC     = 4;
  localparam int DEF_V_BP       = 23;

  // Wide enough to also hold 'total' itself, so sync-end compares never truncate.
  function automatic int cnt_width(input int total);
    return $clog2(total + 1);
  endfunction

endpackage

// File: rtl/pixel_frame_ctrl_if.sv
// Pixel source handshake between the frame buffer reader and the frame controller.
interface pixel_frame_ctrl_if
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] pixel_stream_data;
  logic                  pixel_stream_valid;
  logic                  pixel_stream_ready;

  modport master (
    output pixel_stream_data,
    output pixel_stream_valid,
    input  pixel_stream_ready
  );

  modport slave (
    input  pixel_stream_data,
    input  pixel_stream_valid,
    output pixel_stream_ready
  );

endinterface

// File: rtl/video_timing_counter.sv
// Raster position counters (h, v) and the timing flags decoded from them.
module video_timing_counter
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP
) (
  input  logic pixel_clk,
  input  logic rst,
  input  logic advance,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic start_of_frame,
  output logic end_of_frame
);

  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  // Counters sit at the origin whenever the controller is idle.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (!advance) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign active         = (h < H_ACT) && (v < V_ACT);
  assign hsync          = (h >= HS_BEGIN) && (h < HS_END);
  assign vsync          = (v >= VS_BEGIN) && (v < VS_END);
  assign start_of_frame = (h == '0) && (v == '0);
  assign end_of_frame   = (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Video frame controller: pulls pixels from a source stream into the active
// raster window, registers video timing, and resynchronises after underflow.
//
// state  | meaning
// IDLE   | counters held at origin, no pixels requested, video outputs low
// RUN    | frame scanning, pixels fetched for active positions
// RESYNC | after underflow: drain source to its frame start, blank video data
module pixel_frame_ctrl
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  pixel_clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_underflow,
  pixel_frame_ctrl_if.slave     stream,
  output logic [DATA_WIDTH-1:0] video_data,
  output logic                  video_active,
  output logic                  video_hsync,
  output logic                  video_vsync,
  output logic                  frame_start,
  output logic                  underflow
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NUM_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int SRC_W      = $clog2(NUM_PIXELS);

  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_PIXELS - 1);

  state_t            state;
  state_t            state_nxt;
  logic              ready;
  logic              transfer;
  logic              underflow_evt;
  logic [SRC_W-1:0]  src_count;
  logic [SRC_W-1:0]  src_count_nxt;

  logic tc_active;
  logic tc_hsync;
  logic tc_vsync;
  logic tc_sof;
  logic tc_eof;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_TOTAL  (V_TOTAL)
  ) u_timing (
    .pixel_clk      (pixel_clk),
    .rst            (rst),
    .advance        (state != IDLE),
    .active         (tc_active),
    .hsync          (tc_hsync),
    .vsync          (tc_vsync),
    .start_of_frame (tc_sof),
    .end_of_frame   (tc_eof)
  );

  // In RESYNC the source is drained until its index wraps back to pixel 0.
  always_comb begin
    ready = 1'b0;
    case (state)
      RUN:     ready = tc_active;
      RESYNC:  ready = (src_count != '0);
      default: ready = 1'b0;
    endcase
  end

  assign stream.pixel_stream_ready = ready;
  assign transfer      = ready && stream.pixel_stream_valid;
  assign src_count_nxt = !transfer              ? src_count :
                         (src_count == SRC_LAST) ? '0        : src_count + 1'b1;

  always_comb begin
    state_nxt     = state;
    underflow_evt = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (tc_active && !stream.pixel_stream_valid) begin
          underflow_evt = 1'b1;
          state_nxt     = RESYNC;
        end else if (!enable && tc_eof) begin
          state_nxt = IDLE;
        end
      end
      RESYNC: begin
        if (tc_eof) begin
          if (!enable)                 state_nxt = IDLE;
          else if (src_count_nxt == '0) state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_count <= '0;
    end else begin
      state     <= state_nxt;
      src_count <= src_count_nxt;
    end
  end

  // Video outputs lag the counter position by one cycle.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      video_data   <= '0;
      video_active <= 1'b0;
      video_hsync  <= 1'b0;
      video_vsync  <= 1'b0;
      frame_start  <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      video_data   <= (state == RUN && transfer) ? stream.pixel_stream_data : '0;
      video_active <= (state != IDLE) && tc_active;
      video_hsync  <= (state != IDLE) && tc_hsync;
      video_vsync  <= (state != IDLE) && tc_vsync;
      frame_start  <= (state == RUN) && tc_sof;
      underflow    <= underflow_evt || (underflow && !clear_underflow);
    end
  end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Scoreboard bench for pixel_frame_ctrl on a 7x6 raster (4x3 active).
module tb_pixel_frame_ctrl;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       clear_underflow = 1'b0;
  logic [7:0] video_data;
  logic       video_active;
  logic       video_hsync;
  logic       video_vsync;
  logic       frame_start;
  logic       underflow;

  pixel_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  pixel_frame_ctrl #(
    .DATA_WIDTH (8),
    .H_ACTIVE   (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE   (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut (
    .pixel_clk       (pixel_clk),
    .rst             (rst),
    .enable          (enable),
    .clear_underflow (clear_underflow),
    .stream          (bus),
    .video_data      (video_data),
    .video_active    (video_active),
    .video_hsync     (video_hsync),
    .video_vsync     (video_vsync),
    .frame_start     (frame_start),
    .underflow       (underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [11:0] exp_q[$];

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Pixel source: data = ROM index, optionally withholds pixel 5 once.
  int idx = 0;
  bit drop_armed = 1'b0;
  bit fire;
  bit hit;
  initial begin
    bus.pixel_stream_data  = 8'd0;
    bus.pixel_stream_valid = 1'b1;
    forever begin
      @(negedge pixel_clk);
      fire = bus.pixel_stream_valid && bus.pixel_stream_ready;
      hit  = drop_armed && !bus.pixel_stream_valid && bus.pixel_stream_ready;
      @(posedge pixel_clk);
      #1;
      if (rst) idx = 0;
      else if (fire) idx = (idx + 1) % 12;
      if (hit) drop_armed = 1'b0;
      bus.pixel_stream_data  = 8'(idx);
      bus.pixel_stream_valid = !(drop_armed && idx == 5);
    end
  end

  // Monitor: every non-blank output cycle must match the next expected entry.
  always @(negedge pixel_clk) begin : monitor
    logic [11:0] got_v;
    logic [11:0] exp_v;
    got_v = {frame_start, video_active, video_hsync, video_vsync, video_data};
    if (got_v != '0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected got=%03h expected=none (t=%0t)", got_v, $time);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL out_seq got=%03h expected=%03h {fs,act,hs,vs,data} (t=%0t)",
                   got_v, exp_v, $time);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, expv);
    end
  endtask

  // mode 1: pixels from index 5 onward are blanked (underflow + drain).
  // Only entries up to raster position last_pos (v*7+h) are queued.
  task automatic push_frame(input int mode, input int last_pos);
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 7; h++) begin
        logic [11:0] e;
        logic        act;
        int          pix;
        if (v * 7 + h > last_pos) return;
        act     = (h < 4) && (v < 3);
        pix     = v * 4 + h;
        e[7:0]  = (act && !(mode == 1 && pix >= 5)) ? 8'(pix) : 8'd0;
        e[8]    = (v == 4);
        e[9]    = (h == 5);
        e[10]   = act;
        e[11]   = (h == 0) && (v == 0);
        if (e != '0) exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pixel_clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    if (frame_start !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s got=no_frame_start expected=frame_start", name);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data"},   int'(video_data),   0);
    check({tag, "_active"}, int'(video_active), 0);
    check({tag, "_hsync"},  int'(video_hsync),  0);
    check({tag, "_vsync"},  int'(video_vsync),  0);
    check({tag, "_fs"},     int'(frame_start),  0);
    check({tag, "_ready"},  int'(bus.pixel_stream_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_quiet("reset");
    check("reset_underflow", int'(underflow), 0);

    // Two clean frames, one underflow frame, then a clean frame after drain.
    push_frame(0, 41);
    push_frame(0, 41);
    push_frame(1, 41);
    push_frame(0, 41);
    #1;
    enable = 1'b1;
    rst    = 1'b0;

    wait_fs("fs_frame1");
    t1 = cyc;
    wait_fs("fs_frame2");
    check("frame_period", cyc - t1, 42);

    repeat (20) @(negedge pixel_clk);
    #1 drop_armed = 1'b1;

    wait_fs("fs_frame3");
    repeat (12) @(negedge pixel_clk);
    check("underflow_set", int'(underflow), 1);

    wait_fs("fs_frame4");
    check("underflow_sticky", int'(underflow), 1);
    @(posedge pixel_clk); #1 clear_underflow = 1'b1;
    @(posedge pixel_clk); #1 clear_underflow = 1'b0;
    @(negedge pixel_clk);
    check("underflow_cleared", int'(underflow), 0);

    // Drop enable mid-frame: frame 4 completes, nothing follows.
    repeat (6) @(negedge pixel_clk);
    #1 enable = 1'b0;
    repeat (50) @(negedge pixel_clk);
    #1;
    check_quiet("idle");
    check("idle_queue_empty", exp_q.size(), 0);

    // Frame 5: underflow at pixel 5 with a coincident clear, reset at pixel 7.
    push_frame(1, 9);
    drop_armed = 1'b1;
    enable     = 1'b1;
    wait_fs("fs_frame5");
    repeat (7) @(posedge pixel_clk);
    #1 clear_underflow = 1'b1;
    @(posedge pixel_clk);
    #1 clear_underflow = 1'b0;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    #1;
    check("underflow_clear_collision", int'(underflow), 1);
    check("pre_rst_ready", int'(bus.pixel_stream_ready), 1);
    check("pre_rst_active", int'(video_active), 1);
    rst = 1'b1;
    #1;
    check_quiet("async_rst");
    check("async_rst_underflow", int'(underflow), 0);
    check("pre_rst_queue_empty", exp_q.size(), 0);

    repeat (2) @(posedge pixel_clk);
    push_frame(0, 41);
    @(negedge pixel_clk);
    #1 rst = 1'b0;
    wait_fs("fs_frame6");
    repeat (8) @(negedge pixel_clk);
    #1 enable = 1'b0;
    repeat (50) @(negedge pixel_clk);
    #1;
    check_quiet("final");
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_frame_ctrl.md
PIXEL_FRAME_CTRL -- requirements
Module: pixel_frame_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, pixel width; H_ACTIVE, 800; H_FP, 40; H_SYNC, 128; H_BP, 88; V_ACTIVE, 600; V_FP, 1; V_SYNC, 4; V_BP, 23 (line/pixel counts).
REQ-002 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise, and NUM_PIXELS = H_ACTIVE*V_ACTIVE as localparams.
REQ-003 SHALL have ports: pixel_clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: enable  in  1  start/continue frames; clear_underflow  in  1  clears sticky flag.
REQ-005 SHALL have ports: pixel_stream_data  in  DATA_WIDTH  source pixel; pixel_stream_valid  in  1; pixel_stream_ready  out  1.
REQ-006 SHALL have ports: video_data  out  DATA_WIDTH; video_active  out  1; video_hsync  out  1; video_vsync  out  1; frame_start  out  1  one-cycle pulse; underflow  out  1  sticky error.

Function
REQ-007 SHALL hold counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1); h wraps to 0 and increments v at H_TOTAL-1; v wraps to 0 at V_TOTAL-1.
REQ-008 SHALL define active = (h < H_ACTIVE) & (v < V_ACTIVE); hsync = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync same form on v; both active-high.
REQ-009 SHALL implement states IDLE, RUN, RESYNC.
REQ-010 IDLE: h=v=0 held; ready=0; enable=1 -> RUN next cycle, counters start advancing from (0,0) in RUN.
REQ-011 RUN: pixel_stream_ready = active (combinational from counters); a transfer occurs when ready & valid.
REQ-012 RUN, active & !valid (underflow): video_data for that position = 0, underflow set, state -> RESYNC next cycle; counters continue.
REQ-013 RUN, enable=0: finish current frame; at (H_TOTAL-1, V_TOTAL-1) -> IDLE; otherwise stay RUN.
REQ-014 RESYNC: ready = (src_count != 0) independent of active; accepted pixels discarded; video_data = 0 during active positions.
REQ-015 RESYNC: at (H_TOTAL-1, V_TOTAL-1), next state = RUN if src_count after this cycle's transfer is 0 and enable=1, IDLE if enable=0, else stay RESYNC.
REQ-016 SHALL keep src_count (width clog2(NUM_PIXELS)), incremented on every transfer in any state, wrapping NUM_PIXELS-1 -> 0; tracks source ROM index.
REQ-017 All video_* outputs SHALL be registered: value for counter position (h,v) appears one cycle later; hsync/vsync/active for blanking are produced in RUN and RESYNC, forced 0 in IDLE.
REQ-018 frame_start SHALL pulse for exactly one cycle, aligned with video output of (0,0), only when that position is in RUN.
REQ-019 underflow SHALL stay 1 until clear_underflow=1; simultaneous new underflow and clear -> underflow remains 1.
REQ-020 video_data SHALL equal captured pixel_stream_data on transfer in RUN, else 0.

Reset
REQ-021 rst=1 SHALL asynchronously force state=IDLE, h=v=0, src_count=0, video_data=0, video_active=0, video_hsync=0, video_vsync=0, frame_start=0, underflow=0; pixel_stream_ready=0 while IDLE.
REQ-022 rst mid-frame SHALL abandon the frame; source is assumed reset by the same rst, keeping src_count aligned.

Structure
REQ-023 A shared package SHALL hold the state encoding (IDLE/RUN/RESYNC) and default timing constants.
REQ-024 One sub-module video_timing_counter SHALL hold h/v counters and produce active/hsync/vsync/end_of_frame; FSM, src_count, output registers stay in top.

Verification (H_ACTIVE=4,H_FP=1,H_SYNC=1,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1; H_TOTAL=7,V_TOTAL=6,NUM_PIXELS=12)
REQ-025 Reset, enable=1, source always valid with data=index -> video_data 0..11 across 3 lines, 4 per line, frame_start once per 42 cycles, second frame repeats 0..11.
REQ-026 hsync check -> video_hsync high exactly for h=5 (one cycle per 7-cycle line, delayed one cycle); video_vsync high for all 7 cycles of v=4.
REQ-027 Drop valid for one cycle at pixel 5 -> video_data 0 there, underflow=1, RESYNC drains so the next RUN frame starts with data 0; clear_underflow -> underflow=0.
REQ-028 Deassert enable mid-frame -> frame completes, state IDLE, all video outputs 0, ready=0 after last position.
REQ-029 Assert rst during active pixel 7 -> all outputs 0 immediately (no clock edge), underflow=0, restart produces data 0 at first active position.
